// File: rtl/bp_stream_host_arbiter_if.sv
// Stream signals shared between the per-core requesters, the host bridge and
// the host arbiter. The slave modport is the arbiter's view.
interface bp_stream_host_arbiter_if #(
    parameter int num_req_p           = 4,
    parameter int stream_data_width_p = 32
);
    logic [num_req_p-1:0]                     req_v_i;
    logic [num_req_p*stream_data_width_p-1:0] req_data_i;
    logic [num_req_p-1:0]                     req_resp_i;
    logic [num_req_p-1:0]                     req_yumi_o;

    logic                                     stream_v_o;
    logic [stream_data_width_p-1:0]           stream_data_o;
    logic                                     stream_yumi_i;

    logic                                     stream_v_i;
    logic [stream_data_width_p-1:0]           stream_data_i;
    logic                                     stream_ready_o;

    logic [num_req_p-1:0]                     resp_v_o;
    logic [stream_data_width_p-1:0]           resp_data_o;
    logic [num_req_p-1:0]                     resp_ready_i;

    modport slave (
        input  req_v_i, req_data_i, req_resp_i,
        output req_yumi_o,
        output stream_v_o, stream_data_o,
        input  stream_yumi_i,
        input  stream_v_i, stream_data_i,
        output stream_ready_o,
        output resp_v_o, resp_data_o,
        input  resp_ready_i
    );

    modport master (
        output req_v_i, req_data_i, req_resp_i,
        input  req_yumi_o,
        input  stream_v_o, stream_data_o,
        output stream_yumi_i,
        output stream_v_i, stream_data_i,
        input  stream_ready_o,
        input  resp_v_o, resp_data_o,
        output resp_ready_i
    );
endinterface

// File: rtl/bp_stream_host_arbiter.sv
// Round-robin, packet-locked arbiter sharing one host stream link between
// several requesters, with an in-order tag FIFO steering responses back.
module bp_stream_host_arbiter #(
    parameter int num_req_p           = 4,
    parameter int stream_data_width_p = 32,
    parameter int packet_words_p      = 2,
    parameter int resp_words_p        = 2,
    parameter int order_els_p         = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    bp_stream_host_arbiter_if.slave bus
);

    localparam int id_w       = $clog2(num_req_p);
    localparam int pkt_cnt_w  = (packet_words_p > 1) ? $clog2(packet_words_p) : 1;
    localparam int resp_cnt_w = (resp_words_p > 1) ? $clog2(resp_words_p) : 1;
    localparam int ptr_w      = (order_els_p > 1) ? $clog2(order_els_p) : 1;
    localparam int fcnt_w     = $clog2(order_els_p + 1);

    localparam logic [pkt_cnt_w-1:0]  pkt_last  = pkt_cnt_w'(packet_words_p - 1);
    localparam logic [resp_cnt_w-1:0] resp_last = resp_cnt_w'(resp_words_p - 1);
    localparam logic [fcnt_w-1:0]     fifo_max  = fcnt_w'(order_els_p);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    function automatic logic [id_w-1:0] next_id(input logic [id_w-1:0] id);
        return (id == id_w'(num_req_p - 1)) ? '0 : id + 1'b1;
    endfunction

    function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] ptr);
        return (ptr == ptr_w'(order_els_p - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Scanning downward lets the last hit be the first valid at or after start.
    function automatic logic [id_w-1:0] rr_pick(input logic [num_req_p-1:0] v,
                                                input logic [id_w-1:0]      start);
        logic [id_w-1:0] pick;
        logic [id_w-1:0] idx;
        pick = start;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            idx = id_w'((int'(start) + k) % num_req_p);
            if (v[idx]) pick = idx;
        end
        return pick;
    endfunction

    logic [stream_data_width_p-1:0] req_words [num_req_p];

    for (genvar g = 0; g < num_req_p; g++) begin : g_unpack
        assign req_words[g] = bus.req_data_i[g*stream_data_width_p +: stream_data_width_p];
    end

    state_e                 state_q, state_d;
    logic [id_w-1:0]        id_q, id_d;
    logic [id_w-1:0]        rr_q, rr_d;
    logic [pkt_cnt_w-1:0]   cnt_q, cnt_d;
    logic [resp_cnt_w-1:0]  rcnt_q, rcnt_d;

    logic [id_w-1:0]        tag_mem [order_els_p];
    logic [ptr_w-1:0]       wptr_q, wptr_d;
    logic [ptr_w-1:0]       rptr_q, rptr_d;
    logic [fcnt_w-1:0]      fcnt_q, fcnt_d;

    logic                   fifo_full, fifo_v;
    logic                   push, pop;
    logic [id_w-1:0]        mux_id;
    logic                   out_v;
    logic [num_req_p-1:0]   yumi;
    logic [id_w-1:0]        head_id;
    logic                   in_ready;
    logic                   accept;
    logic [num_req_p-1:0]   resp_v;

    // The full test uses registered state only, so a same-cycle pop never unblocks a grant.
    assign fifo_full = (fcnt_q == fifo_max);
    assign fifo_v    = (fcnt_q != '0);

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        mux_id  = id_q;
        out_v   = 1'b0;
        push    = 1'b0;
        yumi    = '0;

        unique case (state_q)
            IDLE: begin
                mux_id = rr_pick(bus.req_v_i, rr_q);
                out_v  = ~reset_i & ~fifo_full & (|bus.req_v_i);
                if (out_v && bus.stream_yumi_i) begin
                    id_d = mux_id;
                    push = bus.req_resp_i[mux_id];
                    if (packet_words_p == 1) begin
                        rr_d = next_id(mux_id);
                    end else begin
                        cnt_d   = pkt_cnt_w'(1);
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                out_v = ~reset_i & bus.req_v_i[id_q];
                if (out_v && bus.stream_yumi_i) begin
                    if (cnt_q == pkt_last) begin
                        cnt_d   = '0;
                        rr_d    = next_id(id_q);
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase

        yumi[mux_id] = out_v & bus.stream_yumi_i;
    end

    assign bus.stream_v_o    = out_v;
    assign bus.stream_data_o = req_words[mux_id];
    assign bus.req_yumi_o    = yumi;

    // Inbound words follow the oldest outstanding tag; the data itself is broadcast.
    always_comb begin
        head_id         = tag_mem[rptr_q];
        resp_v          = '0;
        resp_v[head_id] = ~reset_i & fifo_v & bus.stream_v_i;
        in_ready        = ~reset_i & fifo_v & bus.resp_ready_i[head_id];
        accept          = in_ready & bus.stream_v_i;
        pop             = accept & (rcnt_q == resp_last);
        rcnt_d          = rcnt_q;
        if (accept) begin
            rcnt_d = pop ? '0 : rcnt_q + 1'b1;
        end
    end

    assign bus.stream_ready_o = in_ready;
    assign bus.resp_v_o       = resp_v;
    assign bus.resp_data_o    = bus.stream_data_i;

    always_comb begin
        wptr_d = push ? next_ptr(wptr_q) : wptr_q;
        rptr_d = pop ? next_ptr(rptr_q) : rptr_q;
        fcnt_d = fcnt_q;
        unique case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + 1'b1;
            2'b01:   fcnt_d = fcnt_q - 1'b1;
            default: fcnt_d = fcnt_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            id_q    <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // NOTE: the tag storage is not reset; the reset pointers and count make stale entries unreachable.
    always_ff @(posedge clk_i) begin
        if (push) begin
            tag_mem[wptr_q] <= mux_id;
        end
    end

    a_yumi_onehot: assert property (@(posedge clk_i) disable iff (reset_i)
        $onehot0(bus.req_yumi_o));

    a_v_has_source: assert property (@(posedge clk_i) disable iff (reset_i)
        bus.stream_v_o |-> bus.req_v_i[mux_id]);

endmodule

// File: tb/tb_bp_stream_host_arbiter.sv
// Directed bench for bp_stream_host_arbiter: reset, single packet, fairness,
// backpressure, response ordering, full/empty tag FIFO and mid-packet reset.
module tb_bp_stream_host_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    bp_stream_host_arbiter_if #(.num_req_p(4), .stream_data_width_p(32)) bus_if ();

    bp_stream_host_arbiter #(
        .num_req_p(4), .stream_data_width_p(32), .packet_words_p(2),
        .resp_words_p(2), .order_els_p(16)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int i, input logic [31:0] val);
        bus_if.req_data_i[i*32 +: 32] = val;
    endtask

    task automatic clear_inputs();
        bus_if.req_v_i       = '0;
        bus_if.req_data_i    = '0;
        bus_if.req_resp_i    = '0;
        bus_if.stream_yumi_i = 1'b0;
        bus_if.stream_v_i    = 1'b0;
        bus_if.stream_data_i = '0;
        bus_if.resp_ready_i  = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_if.req_v_i       = 4'b1111;
        bus_if.stream_yumi_i = 1'b1;
        bus_if.stream_v_i    = 1'b1;
        bus_if.resp_ready_i  = 4'b1111;
        #1;
        checks++;
        if (bus_if.stream_v_o !== 1'b0) begin errors++; $display("FAIL reset_stream_v: got %b expected 0", bus_if.stream_v_o); end
        checks++;
        if (bus_if.req_yumi_o !== 4'b0000) begin errors++; $display("FAIL reset_yumi: got %b expected 0000", bus_if.req_yumi_o); end
        checks++;
        if (bus_if.stream_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus_if.stream_ready_o); end
        checks++;
        if (bus_if.resp_v_o !== 4'b0000) begin errors++; $display("FAIL reset_resp_v: got %b expected 0000", bus_if.resp_v_o); end
        tick();
        tick();
        reset = 1'b0;
        clear_inputs();
        bus_if.stream_v_i   = 1'b1;
        bus_if.resp_ready_i = 4'b1111;
        #1;
        checks++;
        if (bus_if.stream_ready_o !== 1'b0) begin errors++; $display("FAIL post_reset_ready: got %b expected 0", bus_if.stream_ready_o); end
        checks++;
        if (bus_if.stream_v_o !== 1'b0) begin errors++; $display("FAIL post_reset_stream_v: got %b expected 0", bus_if.stream_v_o); end
        tick();
        bus_if.req_v_i       = 4'b1111;
        bus_if.stream_yumi_i = 1'b1;
        #1;
        checks++;
        if (bus_if.req_yumi_o !== 4'b0001) begin errors++; $display("FAIL post_reset_grant: got %b expected 0001", bus_if.req_yumi_o); end
    endtask

    task automatic test_single();
        bus_if.req_v_i       = 4'b0100;
        bus_if.req_resp_i    = 4'b0100;
        bus_if.stream_yumi_i = 1'b1;
        bus_if.stream_v_i    = 1'b1;
        bus_if.stream_data_i = 32'h11;
        bus_if.resp_ready_i  = 4'b1111;
        set_word(2, 32'hA0);
        #1;
        checks++;
        if (bus_if.stream_v_o !== 1'b1) begin errors++; $display("FAIL single_v0: got %b expected 1", bus_if.stream_v_o); end
        checks++;
        if (bus_if.stream_data_o !== 32'hA0) begin errors++; $display("FAIL single_data0: got %h expected a0", bus_if.stream_data_o); end
        checks++;
        if (bus_if.req_yumi_o !== 4'b0100) begin errors++; $display("FAIL single_yumi0: got %b expected 0100", bus_if.req_yumi_o); end
        checks++;
        if (bus_if.stream_ready_o !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %b expected 0", bus_if.stream_ready_o); end
        tick();
        set_word(2, 32'hD0);
        #1;
        checks++;
        if (bus_if.stream_data_o !== 32'hD0) begin errors++; $display("FAIL single_data1: got %h expected d0", bus_if.stream_data_o); end
        checks++;
        if (bus_if.req_yumi_o !== 4'b0100) begin errors++; $display("FAIL single_yumi1: got %b expected 0100", bus_if.req_yumi_o); end
        checks++;
        if (bus_if.stream_ready_o !== 1'b1) begin errors++; $display("FAIL single_ready1: got %b expected 1", bus_if.stream_ready_o); end
        checks++;
        if (bus_if.resp_v_o !== 4'b0100 || bus_if.resp_data_o !== 32'h11) begin
            errors++; $display("FAIL single_resp1: got %b/%h expected 0100/11", bus_if.resp_v_o, bus_if.resp_data_o);
        end
        tick();
        bus_if.req_v_i       = '0;
        bus_if.stream_yumi_i = 1'b0;
        bus_if.stream_data_i = 32'h22;
        #1;
        checks++;
        if (bus_if.stream_v_o !== 1'b0) begin errors++; $display("FAIL single_idle_v: got %b expected 0", bus_if.stream_v_o); end
        checks++;
        if (bus_if.resp_v_o !== 4'b0100 || bus_if.resp_data_o !== 32'h22 || bus_if.stream_ready_o !== 1'b1) begin
            errors++; $display("FAIL single_resp2: got %b/%h/%b expected 0100/22/1", bus_if.resp_v_o, bus_if.resp_data_o, bus_if.stream_ready_o);
        end
        tick();
        #1;
        checks++;
        if (bus_if.stream_ready_o !== 1'b0 || bus_if.resp_v_o !== 4'b0000) begin
            errors++; $display("FAIL single_empty: got %b/%b expected 0/0000", bus_if.stream_ready_o, bus_if.resp_v_o);
        end
        clear_inputs();
    endtask

    task automatic test_fairness();
        int widx [4];
        int exp_id;
        for (int i = 0; i < 4; i++) widx[i] = 0;
        bus_if.req_v_i       = 4'b1111;
        bus_if.stream_yumi_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            exp_id = (c / 2) % 4;
            for (int i = 0; i < 4; i++) set_word(i, 32'(i * 16 + widx[i]));
            #1;
            checks++;
            if (bus_if.req_yumi_o !== 4'(1 << exp_id)) begin
                errors++; $display("FAIL fair_yumi c%0d: got %b expected %b", c, bus_if.req_yumi_o, 4'(1 << exp_id));
            end
            checks++;
            if (bus_if.stream_data_o !== 32'(exp_id * 16 + c % 2)) begin
                errors++; $display("FAIL fair_data c%0d: got %h expected %h", c, bus_if.stream_data_o, 32'(exp_id * 16 + c % 2));
            end
            for (int i = 0; i < 4; i++) if (bus_if.req_yumi_o[i]) widx[i] = 1 - widx[i];
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        bus_if.req_v_i       = 4'b0001;
        bus_if.stream_yumi_i = 1'b1;
        set_word(0, 32'hB0);
        #1;
        checks++;
        if (bus_if.req_yumi_o !== 4'b0001) begin errors++; $display("FAIL bp_first: got %b expected 0001", bus_if.req_yumi_o); end
        tick();
        set_word(0, 32'hB1);
        set_word(1, 32'hC0);
        bus_if.req_v_i       = 4'b0011;
        bus_if.stream_yumi_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (bus_if.stream_v_o !== 1'b1 || bus_if.stream_data_o !== 32'hB1 || bus_if.req_yumi_o !== 4'b0000) begin
                errors++; $display("FAIL bp_stall c%0d: got %b/%h/%b expected 1/b1/0000", c, bus_if.stream_v_o, bus_if.stream_data_o, bus_if.req_yumi_o);
            end
            tick();
        end
        bus_if.req_v_i       = 4'b0010;
        bus_if.stream_yumi_i = 1'b1;
        #1;
        checks++;
        if (bus_if.stream_v_o !== 1'b0 || bus_if.req_yumi_o !== 4'b0000) begin
            errors++; $display("FAIL bp_src_drop: got %b/%b expected 0/0000", bus_if.stream_v_o, bus_if.req_yumi_o);
        end
        tick();
        bus_if.req_v_i = 4'b0011;
        #1;
        checks++;
        if (bus_if.stream_data_o !== 32'hB1 || bus_if.req_yumi_o !== 4'b0001) begin
            errors++; $display("FAIL bp_finish: got %h/%b expected b1/0001", bus_if.stream_data_o, bus_if.req_yumi_o);
        end
        tick();
        #1;
        checks++;
        if (bus_if.stream_data_o !== 32'hC0 || bus_if.req_yumi_o !== 4'b0010) begin
            errors++; $display("FAIL bp_next_grant: got %h/%b expected c0/0010", bus_if.stream_data_o, bus_if.req_yumi_o);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_ordering();
        logic [3:0] req_seq [3];
        logic [3:0] exp_v;
        req_seq[0] = 4'b1000;
        req_seq[1] = 4'b0001;
        req_seq[2] = 4'b0010;
        bus_if.req_resp_i    = 4'b1001;
        bus_if.stream_yumi_i = 1'b1;
        for (int p = 0; p < 3; p++) begin
            bus_if.req_v_i = req_seq[p];
            #1;
            checks++;
            if (bus_if.req_yumi_o !== req_seq[p]) begin
                errors++; $display("FAIL order_grant p%0d: got %b expected %b", p, bus_if.req_yumi_o, req_seq[p]);
            end
            tick();
            tick();
        end
        bus_if.req_v_i       = '0;
        bus_if.stream_yumi_i = 1'b0;
        bus_if.stream_v_i    = 1'b1;
        bus_if.stream_data_i = 32'h55;
        bus_if.resp_ready_i  = 4'b0111;
        #1;
        checks++;
        if (bus_if.stream_ready_o !== 1'b0 || bus_if.resp_v_o !== 4'b1000) begin
            errors++; $display("FAIL order_head_not_ready: got %b/%b expected 0/1000", bus_if.stream_ready_o, bus_if.resp_v_o);
        end
        tick();
        bus_if.resp_ready_i = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            exp_v = (k < 2) ? 4'b1000 : 4'b0001;
            bus_if.stream_data_i = 32'(16'h60 + k);
            #1;
            checks++;
            if (bus_if.stream_ready_o !== 1'b1 || bus_if.resp_v_o !== exp_v) begin
                errors++; $display("FAIL order_route k%0d: got %b/%b expected 1/%b", k, bus_if.stream_ready_o, bus_if.resp_v_o, exp_v);
            end
            tick();
        end
        #1;
        checks++;
        if (bus_if.stream_ready_o !== 1'b0 || bus_if.resp_v_o !== 4'b0000) begin
            errors++; $display("FAIL order_drained: got %b/%b expected 0/0000", bus_if.stream_ready_o, bus_if.resp_v_o);
        end
        clear_inputs();
    endtask

    task automatic test_full_empty();
        bus_if.req_v_i       = 4'b0001;
        bus_if.req_resp_i    = 4'b0001;
        bus_if.stream_yumi_i = 1'b1;
        for (int p = 0; p < 16; p++) begin
            set_word(0, 32'(p * 2));
            #1;
            checks++;
            if (bus_if.req_yumi_o !== 4'b0001) begin
                errors++; $display("FAIL full_fill p%0d: got %b expected 0001", p, bus_if.req_yumi_o);
            end
            tick();
            set_word(0, 32'(p * 2 + 1));
            tick();
        end
        bus_if.stream_v_i    = 1'b1;
        bus_if.stream_data_i = 32'h77;
        bus_if.resp_ready_i  = 4'b1111;
        #1;
        checks++;
        if (bus_if.stream_v_o !== 1'b0 || bus_if.req_yumi_o !== 4'b0000) begin
            errors++; $display("FAIL full_blocked: got %b/%b expected 0/0000", bus_if.stream_v_o, bus_if.req_yumi_o);
        end
        checks++;
        if (bus_if.stream_ready_o !== 1'b1) begin errors++; $display("FAIL full_ready: got %b expected 1", bus_if.stream_ready_o); end
        tick();
        #1;
        checks++;
        if (bus_if.stream_v_o !== 1'b0) begin errors++; $display("FAIL full_pop_same_cycle: got %b expected 0", bus_if.stream_v_o); end
        tick();
        bus_if.stream_v_i = 1'b0;
        #1;
        checks++;
        if (bus_if.stream_v_o !== 1'b1 || bus_if.req_yumi_o !== 4'b0001) begin
            errors++; $display("FAIL full_unblocked: got %b/%b expected 1/0001", bus_if.stream_v_o, bus_if.req_yumi_o);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        bus_if.req_v_i       = 4'b0100;
        bus_if.stream_yumi_i = 1'b1;
        tick();
        tick();
        bus_if.req_v_i    = 4'b1000;
        bus_if.req_resp_i = 4'b1000;
        set_word(3, 32'h3A);
        #1;
        checks++;
        if (bus_if.req_yumi_o !== 4'b1000) begin errors++; $display("FAIL rmid_grant: got %b expected 1000", bus_if.req_yumi_o); end
        tick();
        reset                = 1'b1;
        bus_if.stream_v_i    = 1'b1;
        bus_if.resp_ready_i  = 4'b1111;
        #1;
        checks++;
        if (bus_if.stream_v_o !== 1'b0 || bus_if.req_yumi_o !== 4'b0000 || bus_if.stream_ready_o !== 1'b0 || bus_if.resp_v_o !== 4'b0000) begin
            errors++; $display("FAIL rmid_in_reset: got %b/%b/%b/%b expected 0/0000/0/0000", bus_if.stream_v_o, bus_if.req_yumi_o, bus_if.stream_ready_o, bus_if.resp_v_o);
        end
        tick();
        reset                = 1'b0;
        bus_if.req_v_i       = '0;
        bus_if.stream_yumi_i = 1'b0;
        #1;
        checks++;
        if (bus_if.stream_v_o !== 1'b0 || bus_if.req_yumi_o !== 4'b0000) begin
            errors++; $display("FAIL rmid_after_out: got %b/%b expected 0/0000", bus_if.stream_v_o, bus_if.req_yumi_o);
        end
        checks++;
        if (bus_if.stream_ready_o !== 1'b0 || bus_if.resp_v_o !== 4'b0000) begin
            errors++; $display("FAIL rmid_tags_dropped: got %b/%b expected 0/0000", bus_if.stream_ready_o, bus_if.resp_v_o);
        end
        tick();
        bus_if.req_v_i       = 4'b1111;
        bus_if.stream_yumi_i = 1'b1;
        set_word(0, 32'h0E);
        #1;
        checks++;
        if (bus_if.req_yumi_o !== 4'b0001 || bus_if.stream_data_o !== 32'h0E) begin
            errors++; $display("FAIL rmid_rr_cleared: got %b/%h expected 0001/0e", bus_if.req_yumi_o, bus_if.stream_data_o);
        end
        tick();
        clear_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        clear_inputs();
        test_reset();
        apply_reset();
        test_single();
        apply_reset();
        test_fairness();
        apply_reset();
        test_backpressure();
        apply_reset();
        test_ordering();
        apply_reset();
        test_full_empty();
        apply_reset();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
